// File: rtl/medicine_pkg.sv
// Shared types and constants for the compartment inventory report sequencer.
// LOW_STOCK_FLAG_EN adds the SLOT_FLAG state used to mark empty compartments.
package medicine_pkg;

  localparam int NUM_SLOTS_DEF = 10;
  localparam int CNT_W_DEF     = 4;

  localparam logic [7:0] ASC_ZERO  = 8'h30;
  localparam logic [7:0] ASC_SPACE = 8'h20;
  localparam logic [7:0] ASC_QMARK = 8'h3F;
  localparam logic [7:0] ASC_S     = 8'h53;
  localparam logic [7:0] ASC_CR    = 8'h0D;
  localparam logic [7:0] ASC_LF    = 8'h0A;
  localparam logic [7:0] ASC_BANG  = 8'h21;

  typedef enum logic [3:0] {
    IDLE,
    SLOT_ID,
    SLOT_CNT,
`ifdef LOW_STOCK_FLAG_EN
    SLOT_FLAG,
`endif
    SLOT_SEP,
    SUM_TAG,
    SUM_TENS,
    SUM_ONES,
    CR,
    LF,
    FIN
  } state_t;

endpackage

// File: rtl/digit_to_ascii.sv
// Combinational 4-bit value to ASCII digit; anything above 9 renders as '?'.
module digit_to_ascii
  import medicine_pkg::*;
(
  input  logic [3:0] value,
  output logic [7:0] ascii
);

  always_comb begin
    ascii = (value <= 4'd9) ? (ASC_ZERO + {4'd0, value}) : ASC_QMARK;
  end

endmodule

// File: rtl/medicine_report_seq.sv
// Snapshots all compartment counts on start and streams an ASCII inventory frame to the tx block.
// Optional LOW_STOCK_FLAG_EN appends '!' after the count of every empty compartment.
module medicine_report_seq
  import medicine_pkg::*;
#(
  parameter int NUM_SLOTS = NUM_SLOTS_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [NUM_SLOTS*CNT_W-1:0] counts,
  output logic [7:0]                 tx_data,
  output logic                       tx_valid,
  input  logic                       tx_ready,
  output logic                       busy,
  output logic                       done
);

  localparam int VEC_W = NUM_SLOTS * CNT_W;
  localparam int SEL_W = (VEC_W > 1) ? $clog2(VEC_W) : 1;
  localparam logic [3:0] LAST_IDX = 4'(NUM_SLOTS - 1);

  function automatic logic [3:0] clamp_nib(input logic [CNT_W-1:0] v);
    return (v > CNT_W'(9)) ? 4'hF : 4'(v);
  endfunction

  function automatic logic [6:0] sat_99(input logic [7:0] v);
    return (v > 8'd99) ? 7'd99 : v[6:0];
  endfunction

  state_t            state, state_nxt;
  logic [3:0]        slot_idx, idx_nxt;
  logic              capture;
  logic              xfer;

  logic [VEC_W-1:0]  counts_p0;
  logic [7:0]        sum_p0;
  logic [7:0]        sum_in;

  logic [SEL_W-1:0]  cnt_sel;
  logic [CNT_W-1:0]  cur_cnt;
  logic [3:0]        cnt_nib;
  logic [6:0]        sum_sat;
  logic [3:0]        sum_tens, sum_ones;
  logic [7:0]        cnt_asc, tens_asc, ones_asc;

  always_comb begin
    sum_in = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      sum_in = sum_in + 8'(counts[i*CNT_W +: CNT_W]);
    end
  end

  // Stage p0: snapshot captured once per report; never reset, only loaded on accept
  always_ff @(posedge clk) begin
    if (capture) begin
      counts_p0 <= counts;
      sum_p0    <= sum_in;
    end
  end

  assign cnt_sel  = SEL_W'(slot_idx * CNT_W);
  assign cur_cnt  = counts_p0[cnt_sel +: CNT_W];
  assign cnt_nib  = clamp_nib(cur_cnt);
  assign sum_sat  = sat_99(sum_p0);
  assign sum_tens = 4'(sum_sat / 7'd10);
  assign sum_ones = 4'(sum_sat % 7'd10);

  digit_to_ascii u_cnt_asc  (.value(cnt_nib),  .ascii(cnt_asc));
  digit_to_ascii u_tens_asc (.value(sum_tens), .ascii(tens_asc));
  digit_to_ascii u_ones_asc (.value(sum_ones), .ascii(ones_asc));

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      slot_idx <= '0;
    end else begin
      state    <= state_nxt;
      slot_idx <= idx_nxt;
    end
  end

  assign xfer = tx_valid & tx_ready;

  always_comb begin
    state_nxt = state;
    idx_nxt   = slot_idx;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          capture   = 1'b1;
          idx_nxt   = '0;
          state_nxt = SLOT_ID;
        end
      end
      SLOT_ID:  if (xfer) state_nxt = SLOT_CNT;
`ifdef LOW_STOCK_FLAG_EN
      SLOT_CNT:  if (xfer) state_nxt = (cur_cnt == '0) ? SLOT_FLAG : SLOT_SEP;
      SLOT_FLAG: if (xfer) state_nxt = SLOT_SEP;
`else
      SLOT_CNT:  if (xfer) state_nxt = SLOT_SEP;
`endif
      SLOT_SEP: begin
        if (xfer) begin
          if (slot_idx == LAST_IDX) begin
            state_nxt = SUM_TAG;
          end else begin
            idx_nxt   = slot_idx + 4'd1;
            state_nxt = SLOT_ID;
          end
        end
      end
      SUM_TAG:  if (xfer) state_nxt = SUM_TENS;
      SUM_TENS: if (xfer) state_nxt = SUM_ONES;
      SUM_ONES: if (xfer) state_nxt = CR;
      CR:       if (xfer) state_nxt = LF;
      LF:       if (xfer) state_nxt = FIN;
      FIN:      state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Outputs decode purely from registered state, so they hold steady across stalls
  always_comb begin
    tx_valid = (state != IDLE) && (state != FIN);
    busy     = (state != IDLE) && (state != FIN);
    done     = (state == FIN);
    tx_data  = 8'h00;
    case (state)
      SLOT_ID:   tx_data = ASC_ZERO + {4'd0, slot_idx};
      SLOT_CNT:  tx_data = cnt_asc;
`ifdef LOW_STOCK_FLAG_EN
      SLOT_FLAG: tx_data = ASC_BANG;
`endif
      SLOT_SEP:  tx_data = ASC_SPACE;
      SUM_TAG:   tx_data = ASC_S;
      SUM_TENS:  tx_data = tens_asc;
      SUM_ONES:  tx_data = ones_asc;
      CR:        tx_data = ASC_CR;
      LF:        tx_data = ASC_LF;
      default:   tx_data = 8'h00;
    endcase
  end

endmodule
